mips_step_sequencer: RTL and testbench

//  Synthesizable successor to the hand-written PC-feedback bench loop. Drives the PC input of a

---
 rtl/mips_step_sequencer_pkg.sv | 18 +
 rtl/mips_step_sequencer_if.sv | 43 ++++
 rtl/mips_step_sequencer_fifo.sv | 57 +++++
 rtl/mips_step_sequencer.sv | 116 +++++++++++
 tb/tb_mips_step_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_step_sequencer_pkg.sv
// Shared FSM state encodings and sizing helpers for the step sequencer.
// Latency: n/a.  Backpressure: n/a.
package mips_step_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int trace_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/mips_step_sequencer_if.sv
// Control, core-feedback and trace-read signals of the step sequencer; master = host/core side.
// Latency: n/a.  Backpressure: trace reads are host-paced, FIFO full drops samples.
interface mips_step_sequencer_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STEPS_W = 8
);
  logic                     start;
  logic [STEPS_W-1:0]       num_steps;
  logic [ADDR_W-1:0]        pc_next_i;
  logic [DATA_W-1:0]        result_i;
  logic [ADDR_W-1:0]        pc_o;
  logic                     busy;
  logic                     done;
  logic [STEPS_W-1:0]       step_idx;
  logic                     overflow;
  logic                     trace_rd_en;
  logic [ADDR_W+DATA_W-1:0] trace_rd_data;
  logic                     trace_empty;
  logic                     trace_full;
`ifdef STEP_HALT_EN
  logic [ADDR_W-1:0]        halt_pc_i;
  logic                     halted;

  modport master (
    output start, num_steps, pc_next_i, result_i, trace_rd_en, halt_pc_i,
    input  pc_o, busy, done, step_idx, overflow, trace_rd_data, trace_empty, trace_full, halted
  );
  modport slave (
    input  start, num_steps, pc_next_i, result_i, trace_rd_en, halt_pc_i,
    output pc_o, busy, done, step_idx, overflow, trace_rd_data, trace_empty, trace_full, halted
  );
`else
  modport master (
    output start, num_steps, pc_next_i, result_i, trace_rd_en,
    input  pc_o, busy, done, step_idx, overflow, trace_rd_data, trace_empty, trace_full
  );
  modport slave (
    input  start, num_steps, pc_next_i, result_i, trace_rd_en,
    output pc_o, busy, done, step_idx, overflow, trace_rd_data, trace_empty, trace_full
  );
`endif
endinterface

// File: rtl/mips_step_sequencer_fifo.sv
// Generic first-word-fall-through FIFO, power-of-two depth, synchronous reset.
// Latency: push visible at head next cycle.  Backpressure: push_ok low when full unless popping.
module mips_trace_fifo
  import mips_step_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ok,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);
  localparam int         PW      = ptr_w(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             pop_ok;
  logic             wr_en;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop_ok   = pop & ~empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok  = ~full | pop_ok;
  assign wr_en    = push & push_ok;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_step_sequencer.sv
// Steps a combinational core: drive pc_o, settle, sample {pc,result} into a trace FIFO; STEP_HALT_EN adds halt-PC stop.
// Latency: SETTLE_CYCLES+1 clocks per step, done one cycle after the last sample.
// Backpressure: none on the run; samples hitting a full trace FIFO are dropped and flag overflow.
module mips_step_sequencer
  import mips_step_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                STEPS_W       = 8,
  parameter int                SETTLE_CYCLES = 4,
  parameter int                TRACE_DEPTH   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  mips_step_sequencer_if.slave  bus
);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] result;
  } trace_t;

  localparam int               CNT_W         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   settle_cnt;
  logic [STEPS_W-1:0] steps_left;
  logic [STEPS_W-1:0] step_idx;
  logic [ADDR_W-1:0]  pc_q;
  logic               overflow_q;
  logic               push;
  logic               push_ok;
  logic               halt_hit;
  logic               last_step;
  trace_t             wr_entry;

  assign push      = (state == ST_SAMPLE);
  assign wr_entry  = '{pc: pc_q, result: bus.result_i};
  assign last_step = (steps_left == STEPS_W'(1)) || halt_hit;

`ifdef STEP_HALT_EN
  logic halted_q;

  assign halt_hit   = (bus.pc_next_i == bus.halt_pc_i);
  assign bus.halted = halted_q;

  always_ff @(posedge clock) begin
    if (reset)                                 halted_q <= 1'b0;
    else if (state == ST_IDLE && bus.start)    halted_q <= 1'b0;
    else if (push && halt_hit)                 halted_q <= 1'b1;
  end
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      steps_left <= '0;
      step_idx   <= '0;
      pc_q       <= RESET_PC;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // pc_q is left alone so a new run continues where the last stopped.
          if (bus.start) begin
            step_idx   <= '0;
            overflow_q <= 1'b0;
            steps_left <= bus.num_steps;
            settle_cnt <= SETTLE_RELOAD;
            state      <= (bus.num_steps != '0) ? ST_SETTLE : ST_DONE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_SAMPLE;
          else                  settle_cnt <= settle_cnt - CNT_W'(1);
        end
        ST_SAMPLE: begin
          pc_q       <= bus.pc_next_i;
          step_idx   <= step_idx + STEPS_W'(1);
          steps_left <= steps_left - STEPS_W'(1);
          settle_cnt <= SETTLE_RELOAD;
          if (!push_ok) overflow_q <= 1'b1;
          state <= last_step ? ST_DONE : ST_SETTLE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc_o     = pc_q;
  assign bus.busy     = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.step_idx = step_idx;
  assign bus.overflow = overflow_q;

  mips_trace_fifo #(
    .WIDTH (trace_w(ADDR_W, DATA_W)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (wr_entry),
    .push_ok   (push_ok),
    .pop       (bus.trace_rd_en),
    .pop_data  (bus.trace_rd_data),
    .empty     (bus.trace_empty),
    .full      (bus.trace_full)
  );

endmodule

// File: tb/tb_mips_step_sequencer.sv
// Bench for mips_step_sequencer with a stub core (pc_next = pc+4, result = pc*2), depth-4 trace.
// Runs a table of back-to-back runs, then hand sequences for reset mid-run and pop-then-push on full.
module tb_mips_step_sequencer;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 8;
  localparam int SET = 4;
  localparam int DEP = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mips_step_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .STEPS_W(SW)) bus ();

  assign bus.pc_next_i = bus.pc_o + 32'd4;
  assign bus.result_i  = bus.pc_o << 1;

  mips_step_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .STEPS_W(SW),
    .SETTLE_CYCLES(SET), .TRACE_DEPTH(DEP), .RESET_PC('0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          rst;
    int          n;
    int          exp_idx;
    logic [31:0] exp_pc;
    int          exp_kept;
    bit          exp_ovf;
  } vec_t;

  vec_t        tbl [5];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mpc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.trace_rd_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_run(input int n);
    bus.num_steps = SW'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input string tag, input logic [31:0] pc0, input int kept);
    int          got;
    logic [31:0] p;
    got = 0;
    p   = pc0;
    while (bus.trace_empty === 1'b0 && got < DEP + 2) begin
      chk({tag, "_trace_pc"},  bus.trace_rd_data[63:32], p);
      chk({tag, "_trace_res"}, bus.trace_rd_data[31:0],  p << 1);
      bus.trace_rd_en = 1'b1;
      tick();
      bus.trace_rd_en = 1'b0;
      got++;
      p = p + 32'd4;
    end
    chk({tag, "_trace_count"}, got, kept);
    bus.trace_rd_en = 1'b1;
    tick();
    bus.trace_rd_en = 1'b0;
    chk({tag, "_empty_after_pop_empty"}, bus.trace_empty, 1);
    chk({tag, "_full_after_pop_empty"},  bus.trace_full,  0);
  endtask

  initial begin
    int lat;
    int saw;
    string tag;

    tbl[0] = '{rst: 1, n: 3, exp_idx: 3, exp_pc: 32'd12, exp_kept: 3, exp_ovf: 0};
    tbl[1] = '{rst: 0, n: 0, exp_idx: 0, exp_pc: 32'd12, exp_kept: 0, exp_ovf: 0};
    tbl[2] = '{rst: 0, n: 6, exp_idx: 6, exp_pc: 32'd36, exp_kept: 4, exp_ovf: 1};
    tbl[3] = '{rst: 0, n: 1, exp_idx: 1, exp_pc: 32'd40, exp_kept: 1, exp_ovf: 0};
    tbl[4] = '{rst: 0, n: 4, exp_idx: 4, exp_pc: 32'd56, exp_kept: 4, exp_ovf: 0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_steps = '0;
    bus.trace_rd_en = 1'b0;
`ifdef STEP_HALT_EN
    bus.halt_pc_i = 32'hFFFF_FFFF;
`endif
    do_reset();
    chk("rst_pc",       bus.pc_o,        0);
    chk("rst_busy",     bus.busy,        0);
    chk("rst_done",     bus.done,        0);
    chk("rst_step_idx", bus.step_idx,    0);
    chk("rst_overflow", bus.overflow,    0);
    chk("rst_empty",    bus.trace_empty, 1);
    chk("rst_full",     bus.trace_full,  0);
    mpc = 32'd0;

    for (int i = 0; i < 5; i++) begin
      logic [31:0] pc0;
      tag = $sformatf("row%0d", i);
      if (tbl[i].rst) begin
        do_reset();
        mpc = 32'd0;
      end
      pc0 = mpc;
      start_run(tbl[i].n);
      wait_done(lat);
      chk({tag, "_done_latency"}, lat, tbl[i].n * (SET + 1));
      chk({tag, "_busy_at_done"}, bus.busy, 0);
      chk({tag, "_step_idx"},     bus.step_idx, tbl[i].exp_idx);
      chk({tag, "_pc"},           bus.pc_o, tbl[i].exp_pc);
      chk({tag, "_overflow"},     bus.overflow, tbl[i].exp_ovf);
      chk({tag, "_full"},         bus.trace_full, (tbl[i].exp_kept == DEP) ? 1 : 0);
      tick();
      chk({tag, "_done_pulse"},   bus.done, 0);
      drain(tag, pc0, tbl[i].exp_kept);
      mpc = tbl[i].exp_pc;
    end

    // Reset during the second settle window; a start while busy must be ignored.
    do_reset();
    start_run(5);
    tick();
    tick();
    bus.num_steps = SW'(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("midrun_busy",     bus.busy,        1);
    chk("midrun_step_idx", bus.step_idx,    1);
    chk("midrun_pc",       bus.pc_o,        4);
    chk("midrun_nonempty", bus.trace_empty, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_pc",       bus.pc_o,        0);
    chk("abort_busy",     bus.busy,        0);
    chk("abort_step_idx", bus.step_idx,    0);
    chk("abort_empty",    bus.trace_empty, 1);
    saw = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw++;
      tick();
    end
    chk("abort_no_done", saw, 0);

    // Pop-then-push while full on the sample cycle keeps the sample.
    do_reset();
    start_run(4);
    wait_done(lat);
    chk("pp_fill_full", bus.trace_full, 1);
    tick();
    start_run(1);
    repeat (SET) tick();
    chk("pp_sample_busy", bus.busy, 1);
    bus.trace_rd_en = 1'b1;
    tick();
    bus.trace_rd_en = 1'b0;
    chk("pp_overflow", bus.overflow,   0);
    chk("pp_full",     bus.trace_full, 1);
    wait_done(lat);
    chk("pp_done_overflow", bus.overflow, 0);
    tick();
    drain("pp", 32'd4, 4);

`ifdef STEP_HALT_EN
    do_reset();
    bus.halt_pc_i = 32'd8;
    start_run(10);
    wait_done(lat);
    chk("halt_latency",  lat, 2 * (SET + 1));
    chk("halt_halted",   bus.halted, 1);
    chk("halt_pc",       bus.pc_o, 8);
    chk("halt_step_idx", bus.step_idx, 2);
    tick();
    drain("halt", 32'd0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
